// File: rtl/vector_alu_sequencer.sv
// vector_alu_sequencer
//
// Purpose: steps one vector arithmetic instruction through a 32-bit vector
// ALU slice, one register word at a time. Each word goes through three
// states: READ (issue VRF reads), EXEC (drive the ALU and capture the
// result), and WRITE (write back under per-byte lane enables). It keeps a
// sticky saturation flag and pulses o_done when the instruction retires.
//
// Ports:
//   i_clk, i_rst_n             clock, asynchronous active-low reset
//   i_start / o_ready          instruction handshake (accepted in IDLE only)
//   i_funct6, i_sew, i_vl      operation, element width, active element count
//   i_vm, i_v0                 mask enable (1 = unmasked) and mask bits
//   i_vs1, i_vs2, i_vd         source and destination register indices
//   i_rs1, i_use_scalar        scalar operand and vx-form select
//   o_rf_raddr1/2, i_rf_rdata1/2   VRF reads, data one cycle after address
//   o_rf_we/waddr/wdata/wbe    VRF write port with byte enables
//   o_alu_*, i_alu_result      ALU operands, lane controls and result
//   i_alu_no_ovf               ALU reports no lane overflowed
//   o_done                     one-cycle completion pulse
//   o_vxsat, i_vxsat_clr       sticky saturation flag and its clear
//
// Optional feature: define VPU_SCALAR_OPERAND_EN to let the latched
// i_use_scalar replace the vs1 word with i_rs1 replicated at SEW width.
// Without it, i_rs1 and i_use_scalar are ignored.

module vector_alu_sequencer #(
  parameter int VLEN = 128,
  parameter int NW   = VLEN / 32,
  parameter int VLW  = $clog2(VLEN / 8) + 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_start,
  output logic                      o_ready,
  input  logic [5:0]                i_funct6,
  input  logic [1:0]                i_sew,
  input  logic [VLW-1:0]            i_vl,
  input  logic                      i_vm,
  input  logic [VLEN/8-1:0]         i_v0,
  input  logic [4:0]                i_vs1,
  input  logic [4:0]                i_vs2,
  input  logic [4:0]                i_vd,
  input  logic [31:0]               i_rs1,
  input  logic                      i_use_scalar,
  output logic [5+$clog2(NW)-1:0]   o_rf_raddr1,
  output logic [5+$clog2(NW)-1:0]   o_rf_raddr2,
  input  logic [31:0]               i_rf_rdata1,
  input  logic [31:0]               i_rf_rdata2,
  output logic                      o_rf_we,
  output logic [5+$clog2(NW)-1:0]   o_rf_waddr,
  output logic [31:0]               o_rf_wdata,
  output logic [3:0]                o_rf_wbe,
  output logic [31:0]               o_alu_in1,
  output logic [31:0]               o_alu_in2,
  output logic                      o_alu_8bits,
  output logic                      o_alu_16bits,
  output logic [3:0]                o_alu_masks,
  output logic [5:0]                o_alu_funct6,
  input  logic [31:0]               i_alu_result,
  input  logic                      i_alu_no_ovf,
  output logic                      o_done,
  output logic                      o_vxsat,
  input  logic                      i_vxsat_clr
);

  localparam int WB   = $clog2(NW);
  localparam int AW   = 5 + WB;
  localparam int CW   = VLW + 1;
  localparam int TBW  = VLW + 2;
  localparam int EW   = CW + 2;
  localparam int V0W  = VLEN / 8;
  localparam int V0IW = $clog2(V0W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WRITE,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_stateNext;

  logic [5:0]       r_funct6;
  logic [1:0]       r_sew;
  logic [VLW-1:0]   r_vl;
  logic             r_vm;
  logic [V0W-1:0]   r_v0;
  logic [4:0]       r_vs1;
  logic [4:0]       r_vs2;
  logic [4:0]       r_vd;
  logic [CW-1:0]    r_w;
  logic [CW-1:0]    r_nwords;
  logic [31:0]      r_wdata;
  logic             r_vxsat;

  logic             w_accept;
  logic             w_more;
  logic             w_vxsatSet;
  logic [TBW-1:0]   w_totalBytes;
  logic [CW-1:0]    w_nwords;
  logic [3:0]       w_be;
  logic [31:0]      w_op2;
  logic [AW-1:0]    w_wordAddr;

  assign w_accept   = (r_state == S_IDLE) && i_start;
  assign w_more     = (r_w + CW'(1)) < r_nwords;
  assign w_wordAddr = AW'(r_w) & AW'(NW - 1);

  // The word count is ceil(vl * bytes(sew) / 4). SEW code 11 is treated as 32 bits.
  always_comb begin
    case (i_sew)
      2'b00:   w_totalBytes = TBW'(i_vl);
      2'b01:   w_totalBytes = TBW'({i_vl, 1'b0});
      default: w_totalBytes = TBW'({i_vl, 2'b00});
    endcase
  end

  assign w_nwords = CW'((w_totalBytes + TBW'(3)) >> 2);

  // Byte enables for the current word. Each byte maps to its element, so all
  // bytes of one element share the same enable.
  always_comb begin
    logic [EW-1:0] byteIdx;
    logic [EW-1:0] elemIdx;
    w_be = '0;
    for (int b = 0; b < 4; b++) begin
      byteIdx = {r_w, 2'(b)};
      case (r_sew)
        2'b00:   elemIdx = byteIdx;
        2'b01:   elemIdx = byteIdx >> 1;
        default: elemIdx = byteIdx >> 2;
      endcase
      w_be[b] = (elemIdx < EW'(r_vl)) &&
                (r_vm || ((elemIdx < EW'(V0W)) && r_v0[elemIdx[V0IW-1:0]]));
    end
  end

`ifdef VPU_SCALAR_OPERAND_EN
  logic [31:0] r_rs1;
  logic        r_useScalar;

  // Scalar operand is captured with the rest of the instruction.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rs1       <= '0;
      r_useScalar <= 1'b0;
    end else if (w_accept) begin
      r_rs1       <= i_rs1;
      r_useScalar <= i_use_scalar;
    end
  end

  // In the vx form the vs1 read still happens, but its data is replaced by
  // the scalar replicated across every lane.
  always_comb begin
    w_op2 = i_rf_rdata1;
    if (r_useScalar) begin
      case (r_sew)
        2'b00:   w_op2 = {4{r_rs1[7:0]}};
        2'b01:   w_op2 = {2{r_rs1[15:0]}};
        default: w_op2 = r_rs1;
      endcase
    end
  end
`else
  logic w_unused;
  assign w_unused = ^{i_rs1, i_use_scalar};
  assign w_op2    = i_rf_rdata1;
`endif

  // State register. A reset aborts any instruction in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next state and outputs. Data-path outputs are forced to zero outside the
  // states that use them, so idle and reset values are clean.
  always_comb begin
    w_stateNext  = r_state;
    o_ready      = 1'b0;
    o_done       = 1'b0;
    o_rf_we      = 1'b0;
    o_rf_raddr1  = '0;
    o_rf_raddr2  = '0;
    o_rf_waddr   = '0;
    o_rf_wdata   = '0;
    o_rf_wbe     = '0;
    o_alu_in1    = '0;
    o_alu_in2    = '0;
    o_alu_8bits  = 1'b0;
    o_alu_16bits = 1'b0;
    o_alu_masks  = '0;
    case (r_state)
      S_IDLE: begin
        o_ready = 1'b1;
        if (i_start) begin
          w_stateNext = (i_vl == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        o_rf_raddr1 = (AW'(r_vs1) << WB) | w_wordAddr;
        o_rf_raddr2 = (AW'(r_vs2) << WB) | w_wordAddr;
        w_stateNext = S_EXEC;
      end
      S_EXEC: begin
        o_alu_in1    = i_rf_rdata2;
        o_alu_in2    = w_op2;
        o_alu_8bits  = (r_sew == 2'b00);
        o_alu_16bits = (r_sew == 2'b01);
        o_alu_masks  = w_be;
        w_stateNext  = S_WRITE;
      end
      S_WRITE: begin
        o_rf_we     = 1'b1;
        o_rf_waddr  = (AW'(r_vd) << WB) | w_wordAddr;
        o_rf_wdata  = r_wdata;
        o_rf_wbe    = w_be;
        w_stateNext = w_more ? S_READ : S_DONE;
      end
      S_DONE: begin
        o_done      = 1'b1;
        w_stateNext = S_IDLE;
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  // Instruction latch, word counter and write-data register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_funct6 <= '0;
      r_sew    <= '0;
      r_vl     <= '0;
      r_vm     <= 1'b0;
      r_v0     <= '0;
      r_vs1    <= '0;
      r_vs2    <= '0;
      r_vd     <= '0;
      r_w      <= '0;
      r_nwords <= '0;
      r_wdata  <= '0;
    end else begin
      if (w_accept) begin
        r_funct6 <= i_funct6;
        r_sew    <= i_sew;
        r_vl     <= i_vl;
        r_vm     <= i_vm;
        r_v0     <= i_v0;
        r_vs1    <= i_vs1;
        r_vs2    <= i_vs2;
        r_vd     <= i_vd;
        r_w      <= '0;
        r_nwords <= w_nwords;
      end
      if (r_state == S_EXEC) begin
        r_wdata <= i_alu_result;
      end
      if ((r_state == S_WRITE) && w_more) begin
        r_w <= r_w + CW'(1);
      end
    end
  end

  // Saturation only counts for saturating ops (funct6[5]) on words with at
  // least one enabled lane. A set wins over a simultaneous clear.
  assign w_vxsatSet = (r_state == S_EXEC) && r_funct6[5] && !i_alu_no_ovf && (w_be != 4'b0000);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vxsat <= 1'b0;
    end else if (w_vxsatSet) begin
      r_vxsat <= 1'b1;
    end else if (i_vxsat_clr) begin
      r_vxsat <= 1'b0;
    end
  end

  assign o_vxsat      = r_vxsat;
  assign o_alu_funct6 = r_funct6;

endmodule

// File: tb/tb_vector_alu_sequencer.sv
// tb_vector_alu_sequencer
//
// Purpose: drives vector_alu_sequencer with a behavioural VRF and ALU. It
// predicts each instruction's effect element by element (destination
// register contents, write timing, byte enables, and vxsat) and compares
// the DUT against those predictions.

module tb_vector_alu_sequencer;

  localparam int VLEN = 128;
  localparam int NW   = VLEN / 32;
  localparam int VLW  = $clog2(VLEN / 8) + 1;
  localparam int WB   = $clog2(NW);
  localparam int AW   = 5 + WB;
  localparam logic [5:0] VADD   = 6'b000000;
  localparam logic [5:0] VSADDU = 6'b100000;

  logic              clk = 1'b0;
  logic              rstN;
  logic              start;
  logic              ready;
  logic [5:0]        funct6;
  logic [1:0]        sew;
  logic [VLW-1:0]    vl;
  logic              vm;
  logic [VLEN/8-1:0] v0;
  logic [4:0]        vs1, vs2, vd;
  logic [31:0]       rs1;
  logic              useScalar;
  logic [AW-1:0]     raddr1, raddr2, waddr;
  logic [31:0]       rdata1, rdata2, wdata;
  logic              we;
  logic [3:0]        wbe;
  logic [31:0]       aluIn1, aluIn2, aluResult;
  logic              alu8, alu16, aluNoOvf;
  logic [3:0]        aluMasks;
  logic [5:0]        aluFunct6;
  logic              done;
  logic              vxsat;
  logic              vxsatClr;

  int nChecks = 0;
  int nErrors = 0;
  int cyc = 0;
  int c0 = 0;
  logic expVxsat = 1'b0;

  logic [31:0] rf [0:31][0:NW-1];

  typedef struct {
    int            relCyc;
    logic [AW-1:0] addr;
    logic [3:0]    be;
  } wrRec_t;
  wrRec_t wrLog[$];

  vector_alu_sequencer #(.VLEN(VLEN)) dut (
    .i_clk(clk), .i_rst_n(rstN), .i_start(start), .o_ready(ready),
    .i_funct6(funct6), .i_sew(sew), .i_vl(vl), .i_vm(vm), .i_v0(v0),
    .i_vs1(vs1), .i_vs2(vs2), .i_vd(vd), .i_rs1(rs1), .i_use_scalar(useScalar),
    .o_rf_raddr1(raddr1), .o_rf_raddr2(raddr2),
    .i_rf_rdata1(rdata1), .i_rf_rdata2(rdata2),
    .o_rf_we(we), .o_rf_waddr(waddr), .o_rf_wdata(wdata), .o_rf_wbe(wbe),
    .o_alu_in1(aluIn1), .o_alu_in2(aluIn2),
    .o_alu_8bits(alu8), .o_alu_16bits(alu16), .o_alu_masks(aluMasks),
    .o_alu_funct6(aluFunct6), .i_alu_result(aluResult), .i_alu_no_ovf(aluNoOvf),
    .o_done(done), .o_vxsat(vxsat), .i_vxsat_clr(vxsatClr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // VRF model: registered read, byte-enabled write.
  always @(posedge clk) begin
    rdata1 <= rf[raddr1[AW-1:WB]][raddr1[WB-1:0]];
    rdata2 <= rf[raddr2[AW-1:WB]][raddr2[WB-1:0]];
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wbe[b]) rf[waddr[AW-1:WB]][waddr[WB-1:0]][8*b +: 8] = wdata[8*b +: 8];
      end
    end
  end

  always @(negedge clk) begin
    if (we) wrLog.push_back('{cyc - c0, waddr, wbe});
  end

  // ALU model: lane-wise add or unsigned saturating add.
  function automatic logic [32:0] aluModel(input logic [31:0] a, input logic [31:0] b,
                                           input logic [5:0] f, input logic e8, input logic e16,
                                           input logic [3:0] m);
    int eb;
    logic [63:0] mask;
    logic [63:0] x, y, s;
    logic [31:0] res;
    logic ovf;
    eb = e8 ? 1 : (e16 ? 2 : 4);
    mask = (64'd1 << (8 * eb)) - 64'd1;
    res = '0;
    ovf = 1'b0;
    for (int l = 0; l < 4 / eb; l++) begin
      x = 64'(a >> (8 * eb * l)) & mask;
      y = 64'(b >> (8 * eb * l)) & mask;
      s = x + y;
      if (f == VSADDU && s > mask) begin
        s = mask;
        if (m[l * eb]) ovf = 1'b1;
      end
      s = s & mask;
      res = res | 32'(s << (8 * eb * l));
    end
    return {~ovf, res};
  endfunction

  assign {aluNoOvf, aluResult} = aluModel(aluIn1, aluIn2, aluFunct6, alu8, alu16, aluMasks);

  function automatic logic [VLEN-1:0] getVec(input int r);
    logic [VLEN-1:0] v;
    v = '0;
    for (int k = 0; k < NW; k++) v[32*k +: 32] = rf[r][k];
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [VLEN-1:0] obs, input logic [VLEN-1:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErrors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one instruction. The expected result is computed element by element
  // before the instruction starts, then compared against the DUT.
  task automatic applyStimulus(input string tag, input logic [5:0] f, input logic [1:0] s,
                               input int nvl, input logic m, input logic [15:0] mbits,
                               input int r1, input int r2, input int rd);
    logic [VLEN-1:0] v1, v2, ev;
    logic [63:0] mask, a, b, sum;
    logic [3:0] ewbe;
    int eb, n, sh, e, doneCyc;
    bit seen;
    eb = (s == 2'b00) ? 1 : ((s == 2'b01) ? 2 : 4);
    mask = (64'd1 << (8 * eb)) - 64'd1;
    v1 = getVec(r1);
    v2 = getVec(r2);
    ev = getVec(rd);
    for (int i = 0; i < nvl; i++) begin
      if (m || mbits[i]) begin
        sh = 8 * eb * i;
        a = 64'(v2 >> sh) & mask;
        b = 64'(v1 >> sh) & mask;
        sum = a + b;
        if (f == VSADDU && sum > mask) begin
          sum = mask;
          expVxsat = 1'b1;
        end
        sum = sum & mask;
        ev = (ev & ~(VLEN'(mask) << sh)) | (VLEN'(sum) << sh);
      end
    end
    n = (nvl * eb + 3) / 4;

    @(negedge clk);
    wrLog.delete();
    c0 = cyc;
    funct6 = f; sew = s; vl = VLW'(nvl); vm = m; v0 = mbits;
    vs1 = 5'(r1); vs2 = 5'(r2); vd = 5'(rd); rs1 = $urandom;
    start = 1'b1;
    @(negedge clk);
    // Keep start high and scramble the fields: a busy sequencer must ignore them.
    funct6 = 6'($urandom); sew = 2'($urandom); vl = VLW'($urandom_range(1, 16));
    vm = 1'($urandom); v0 = 16'($urandom);
    vs1 = 5'($urandom); vs2 = 5'($urandom); vd = 5'($urandom);
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      if (done) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    doneCyc = cyc - c0;
    start = 1'b0;
    checkOutput({tag, " doneSeen"}, VLEN'(seen), VLEN'(1));
    checkOutput({tag, " doneCycle"}, VLEN'(doneCyc), VLEN'(3 * n + 1));
    checkOutput({tag, " readyInDone"}, VLEN'(ready), VLEN'(0));
    @(negedge clk);
    checkOutput({tag, " readyAfter"}, VLEN'(ready), VLEN'(1));
    checkOutput({tag, " doneDrop"}, VLEN'(done), VLEN'(0));
    checkOutput({tag, " writeCount"}, VLEN'(wrLog.size()), VLEN'(n));
    for (int k = 0; k < wrLog.size() && k < n; k++) begin
      for (int bb = 0; bb < 4; bb++) begin
        e = (4 * k + bb) / eb;
        ewbe[bb] = (e < nvl) && (m || mbits[e]);
      end
      checkOutput($sformatf("%s wrCycle%0d", tag, k), VLEN'(wrLog[k].relCyc), VLEN'(3 * k + 3));
      checkOutput($sformatf("%s wrAddr%0d", tag, k), VLEN'(wrLog[k].addr), VLEN'(rd * NW + k));
      checkOutput($sformatf("%s wbe%0d", tag, k), VLEN'(wrLog[k].be), VLEN'(ewbe));
    end
    checkOutput({tag, " vdData"}, getVec(rd), ev);
    checkOutput({tag, " vxsat"}, VLEN'(vxsat), VLEN'(expVxsat));
  endtask

  initial begin
    int eb, rvl;
    rstN = 1'b0; start = 1'b0; funct6 = '0; sew = '0; vl = '0; vm = 1'b1; v0 = '0;
    vs1 = '0; vs2 = '0; vd = '0; rs1 = '0; useScalar = 1'b0; vxsatClr = 1'b0;
    for (int r = 0; r < 32; r++)
      for (int k = 0; k < NW; k++) rf[r][k] = $urandom;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst ready", VLEN'(ready), VLEN'(1));
    checkOutput("rst done", VLEN'(done), VLEN'(0));
    checkOutput("rst we", VLEN'(we), VLEN'(0));
    checkOutput("rst vxsat", VLEN'(vxsat), VLEN'(0));
    checkOutput("rst raddr1", VLEN'(raddr1), VLEN'(0));
    checkOutput("rst waddr", VLEN'(waddr), VLEN'(0));
    checkOutput("rst wdata", VLEN'(wdata), VLEN'(0));
    checkOutput("rst wbe", VLEN'(wbe), VLEN'(0));
    checkOutput("rst masks", VLEN'(aluMasks), VLEN'(0));
    rstN = 1'b1;

    // vadd.vv SEW32, vl=4: every word becomes 1 + 10
    for (int k = 0; k < NW; k++) begin rf[1][k] = 32'd1; rf[2][k] = 32'd10; end
    applyStimulus("vaddSew32", VADD, 2'b10, 4, 1'b1, 16'h0, 1, 2, 3);
    for (int k = 0; k < NW; k++) checkOutput($sformatf("vaddSew32 word%0d", k), VLEN'(rf[3][k]), VLEN'(32'd11));

    // SEW8, vl=5: two words, the second with a single enabled byte
    applyStimulus("sew8vl5", VADD, 2'b00, 5, 1'b1, 16'h0, 4, 5, 6);

    // SEW16, masked with v0 = 0101
    applyStimulus("sew16mask", VADD, 2'b01, 4, 1'b0, 16'h0005, 7, 8, 9);

    // vsaddu SEW8 saturates 0xF0 + 0x20
    rf[10][0] = 32'h0000_0020;
    rf[11][0] = 32'h0000_00F0;
    applyStimulus("vsaddu", VSADDU, 2'b00, 1, 1'b1, 16'h0, 10, 11, 12);
    checkOutput("vsaddu byte0", VLEN'(rf[12][0][7:0]), VLEN'(8'hFF));
    checkOutput("vsaddu flagSet", VLEN'(vxsat), VLEN'(1));
    vxsatClr = 1'b1;
    @(negedge clk);
    vxsatClr = 1'b0;
    expVxsat = 1'b0;
    checkOutput("vxsat cleared", VLEN'(vxsat), VLEN'(0));

    // vl = 0: immediate completion, no writes
    applyStimulus("vl0", VADD, 2'b10, 0, 1'b1, 16'h0, 1, 2, 13);

    // Reset during the EXEC of word 1 aborts the instruction
    @(negedge clk);
    wrLog.delete();
    c0 = cyc;
    funct6 = VADD; sew = 2'b10; vl = VLW'(4); vm = 1'b1; vs1 = 5'd1; vs2 = 5'd2; vd = 5'd14;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc - c0 < 5) @(negedge clk);
    rstN = 1'b0;
    #1;
    checkOutput("abort ready", VLEN'(ready), VLEN'(1));
    checkOutput("abort we", VLEN'(we), VLEN'(0));
    checkOutput("abort done", VLEN'(done), VLEN'(0));
    expVxsat = 1'b0;
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    checkOutput("abort writes", VLEN'(wrLog.size()), VLEN'(1));
    @(negedge clk);
    checkOutput("abort noLateWrite", VLEN'(wrLog.size()), VLEN'(1));
    applyStimulus("afterAbort", VADD, 2'b10, 4, 1'b1, 16'h0, 1, 2, 14);

    // Randomized instructions
    for (int t = 0; t < 20; t++) begin
      sew = 2'($urandom_range(0, 3));
      eb = (sew == 2'b00) ? 1 : ((sew == 2'b01) ? 2 : 4);
      rvl = $urandom_range(0, (VLEN / 8) / eb);
      applyStimulus($sformatf("rand%0d", t), ($urandom_range(0, 1) == 1) ? VSADDU : VADD, sew,
                    rvl, 1'($urandom), 16'($urandom),
                    $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
    end

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
